// File: rtl/mul_sequencer.sv
// mul_sequencer: round-robin front end that drives the shared shift-add multiplier
// through FIRST, 31 x MULTU, OUT and returns the product over a valid/ready channel.
module mul_sequencer #(
    parameter logic [5:0] OP_FIRST = 6'b111110,
    parameter logic [5:0] OP_MULTU = 6'b011001,
    parameter logic [5:0] OP_OUT   = 6'b111111,
    parameter logic [5:0] OP_NOP   = 6'b000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic [31:0] a0,
    input  logic [31:0] b0,
    input  logic [31:0] a1,
    input  logic [31:0] b1,
    output logic        ack0,
    output logic        ack1,
    output logic [5:0]  mul_signal,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic [63:0] mul_dout,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic        resp_id,
    output logic [63:0] resp_data,
    output logic        busy
);
    typedef enum logic [2:0] {S_IDLE, S_FIRST, S_STEP, S_OUT, S_DONE} state_t;

    state_t      state_q, state_d;
    logic        last_q, last_d, owner_q, owner_d;
    logic [31:0] a_q, a_d, b_q, b_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [63:0] data_q, data_d;
    logic        idle, pick1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            last_q  <= 1'b1;
            owner_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        owner_d    = owner_q;
        a_d        = a_q;
        b_d        = b_q;
        cnt_d      = cnt_q;
        data_d     = data_q;
        mul_signal = OP_NOP;
        idle       = state_q == S_IDLE;
        // requester 1 wins alone, or on a tie when requester 0 was served last
        pick1      = req1 & (~req0 | ~last_q);
        ack0       = idle & req0 & ~pick1;
        ack1       = idle & pick1;
        case (state_q)
            S_IDLE: if (req0 | req1) begin
                state_d = S_FIRST;
                last_d  = pick1;
                owner_d = pick1;
                a_d     = pick1 ? a1 : a0;
                b_d     = pick1 ? b1 : b0;
            end
            S_FIRST: begin
                mul_signal = OP_FIRST;
                cnt_d      = 5'd1;
                state_d    = S_STEP;
            end
            S_STEP: begin
                mul_signal = OP_MULTU;
                cnt_d      = cnt_q + 5'd1;
                state_d    = cnt_q == 5'd31 ? S_OUT : S_STEP;
            end
            S_OUT: begin
                mul_signal = OP_OUT;
                data_d     = mul_dout;
                state_d    = S_DONE;
            end
            S_DONE: state_d = resp_ready ? S_IDLE : S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    assign mul_a      = a_q;
    assign mul_b      = b_q;
    assign resp_valid = state_q == S_DONE;
    assign resp_id    = owner_q;
    assign resp_data  = data_q;
    assign busy       = state_q != S_IDLE;
endmodule

// File: doc/mul_sequencer.md
# mul_sequencer

Sequences the shared shift-add multiplier for two requesters with round-robin arbitration. The block captures the operands from the granted requester and drives the multiplier's `Signal` opcode stream: FIRST, then 31×MULTU, then OUT. It then returns the 64-bit product on a shared response channel that uses a valid/ready handshake. It sits between the ALU front-end requesters and the multiplier datapath, and is the only driver of that datapath's `Signal`, `dataA` and `dataB` inputs.

## Interface
- `OP_FIRST`, default 6'b111110: opcode that loads B and performs step 1.
- `OP_MULTU`, default 6'b011001: opcode for one shift-add step.
- `OP_OUT`, default 6'b111111: opcode that holds the result.
- `OP_NOP`, default 6'b000000: idle opcode; the datapath does not change state.
- `clk` in 1: clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `req0`, `req1` in 1: request valid, held high by the requester until acked.
- `a0`, `b0`, `a1`, `b1` in 32 each: operands; A is the multiplicand, B is the multiplier.
- `ack0`, `ack1` out 1: accept pulse, combinational, one cycle wide.
- `mul_signal` out 6: opcode to the multiplier.
- `mul_a`, `mul_b` out 32: operands to the multiplier.
- `mul_dout` in 64: multiplier product.
- `resp_valid` out 1: a result is available.
- `resp_ready` in 1: consumer accepts the result.
- `resp_id` out 1: which requester owns the result.
- `resp_data` out 64: the product.
- `busy` out 1: high in any state other than IDLE.

## Operation
- States: IDLE, FIRST, STEP, OUT, DONE. The encoding is free.
- **IDLE**
  - `mul_signal` = OP_NOP.
  - If either `req` is high, grant exactly one: assert `ackN` in that cycle, latch `aN`/`bN` into the operand registers, latch N into `owner`, and go to FIRST.
- **Arbitration**
  - Round-robin on a 1-bit pointer `last`.
  - When both requesters are high, grant the one that is not `last`.
  - After reset `last` = 1, so `req0` wins the first tie.
  - Update `last` only on a grant.
- **FIRST**
  - `mul_signal` = OP_FIRST.
  - Clear the 5-bit step counter to 1, then go to STEP.
- **STEP**
  - `mul_signal` = OP_MULTU and the counter increments each cycle.
  - Leave for OUT in the cycle the counter reads 31, giving 31 MULTU cycles in total.
- **OUT**
  - `mul_signal` = OP_OUT.
  - Capture `mul_dout` into `resp_data` and go to DONE.
- **DONE**
  - `mul_signal` = OP_NOP and `resp_valid` = 1.
  - On `resp_valid & resp_ready`, go to IDLE.
  - No new grant is made in DONE, even when the response handshake completes.
- `mul_a`/`mul_b` always drive the operand registers, which are stable from FIRST through OUT.
- `resp_id` = `owner`.
- `resp_data` and `resp_id` hold unchanged from DONE entry until the handshake completes.
- No arithmetic is done in this block; the product width is 64 with no truncation.

## Timing
- **Reset values:**
  - state IDLE;
  - `mul_signal` OP_NOP;
  - `ack0`/`ack1` 0;
  - `resp_valid` 0, `resp_id` 0, `resp_data` 0;
  - `busy` 0;
  - operand registers 0, counter 0;
  - `last` 1.
- **Latency:** grant in cycle T. Then:
  - FIRST in T+1;
  - MULTU in T+2..T+32;
  - OUT in T+33;
  - `resp_valid` first high in T+34.
- **Throughput:** a zero-stall handshake returns to IDLE at T+35, so the next grant can come no earlier than T+35.
- **Request rules:**
  - A request that drops before it is acked is simply not served.
  - Requests arriving while busy are held by the requester and are not acked.
- **Reset during operation:** an in-flight operation is abandoned with no response. The next cycle is IDLE with reset values, and `mul_signal` = OP_NOP.
- **Response backpressure:** `resp_ready` low in DONE stalls indefinitely. The block stays in DONE and all outputs hold.
- **Simultaneous events:** the ack and the operand latch happen in the same cycle. `ack0` and `ack1` are never high together.

## Test plan
- **Single multiply:** `req0` with `a0`=3, `b0`=5 → `ack0` in cycle T, FIRST at T+1, 31 MULTU, OUT at T+33, then `resp_valid` at T+34 with `resp_data`=15, `resp_id`=0.
- **Larger operands:** `req1` with `a1`=32'h0000FFFF, `b1`=32'h0000FFFF → `resp_data`=64'h00000000FFFE0001, `resp_id`=1. Check the opcode count is exactly 1 FIRST, 31 MULTU, 1 OUT.
- **Tie-break:** `req0` and `req1` held high after reset, `resp_ready`=1, with (a0,b0)=(2,7) and (a1,b1)=(4,9) → results 14 (id 0), then 36 (id 1), then 14 (id 0). Grants are 35 cycles apart.
- **Backpressure:** `resp_ready`=0 for 10 cycles after `resp_valid` rises → the response holds stable, `mul_signal` stays OP_NOP, and no ack is given to a pending `req1`. `ack1` comes in the cycle after the handshake.
- **Reset mid-operation:** `reset` asserted at T+10 → the next cycle is IDLE, `busy`=0, `resp_valid` never asserts. A new `req0` (6×7) then yields 42 normally.
- **Zero operands:** `b0`=0, `a0`=32'hFFFFFFFF → `resp_data`=0 at T+34.
